// File: rtl/fifo_share_pkg.sv
// Shared types and constants for the shared-FIFO controller.
//   turn_t  : whose turn it is when a write and a read compete for the FIFO
//   DEPTH   : capacity of the attached FIFO
//   LEVEL_W : width of the shadow occupancy count
package fifo_share_pkg;

    typedef enum logic {
        TURN_RD = 1'b0,
        TURN_WR = 1'b1
    } turn_t;

    localparam int DEPTH   = 3;
    localparam int LEVEL_W = 2;

endpackage

// File: rtl/fifo_share_ctrl_rr_arb2.sv
// Two-way round-robin picker.
//   clk, resetn : clock, synchronous active-low reset
//   req[1:0]    : request per producer
//   advance     : the current grant was used; move priority past it
//   gnt         : index of the granted requester
//   gnt_valid   : at least one request is present
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt,
    output logic       gnt_valid
);

    logic ptr_reg;
    logic ptr_next;

    always_comb begin
        gnt       = req[ptr_reg] ? ptr_reg : ~ptr_reg;
        gnt_valid = |req;
        // Priority goes to the producer that was not served, even if it
        // is idle right now.
        ptr_next  = advance ? ~gnt : ptr_reg;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one external FIFO between two producers and one consumer.
// Producer writes are arbitrated round-robin; a write and a read are never
// issued in the same cycle, and under contention they alternate. A shadow
// occupancy count is cross-checked against the FIFO's full/empty flags.
//   clk, resetn            : clock, synchronous active-low reset
//   p0_*/p1_*              : producer valid/data in, ready out
//   c_valid/c_data/c_ready : consumer handshake (c_data is the FIFO head)
//   fifo_wr/fifo_rd/fifo_din : FIFO strobes and write data
//   fifo_full/fifo_empty/fifo_dout : FIFO status and head
//   level                  : shadow occupancy
//   err                    : sticky shadow/FIFO disagreement flag
module fifo_share_ctrl
    import fifo_share_pkg::turn_t, fifo_share_pkg::TURN_RD,
           fifo_share_pkg::TURN_WR, fifo_share_pkg::LEVEL_W;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = fifo_share_pkg::DEPTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               p0_valid,
    input  logic [WIDTH-1:0]   p0_data,
    output logic               p0_ready,
    input  logic               p1_valid,
    input  logic [WIDTH-1:0]   p1_data,
    output logic               p1_ready,
    output logic               c_valid,
    output logic [WIDTH-1:0]   c_data,
    input  logic               c_ready,
    output logic               fifo_wr,
    output logic               fifo_rd,
    output logic [WIDTH-1:0]   fifo_din,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_dout,
    output logic [LEVEL_W-1:0] level,
    output logic               err
);

    turn_t              turn_reg, turn_next;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic               err_reg, err_next;

    logic       any_p;
    logic       rd_fire;
    logic       wr_fire;
    logic       contention;
    logic       gnt;
    logic       gnt_valid;
    logic [1:0] ready;

    rr_arb2 u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req       ({p1_valid, p0_valid}),
        .advance   (wr_fire),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        any_p      = gnt_valid;
        // The consumer sees data only when it is the read's turn, or when a
        // write could not happen anyway (no producer, or FIFO full).
        c_valid    = resetn & ~fifo_empty
                     & ((turn_reg == TURN_RD) | ~any_p | fifo_full);
        rd_fire    = c_valid & c_ready;
        // A write yields to a read in the same cycle: the FIFO would drop rd.
        wr_fire    = resetn & any_p & ~fifo_full & ~rd_fire;
        contention = any_p & ~fifo_full & ~fifo_empty;

        turn_next = turn_reg;
        if (contention) begin
            if (rd_fire) begin
                turn_next = TURN_WR;
            end else if (wr_fire) begin
                turn_next = TURN_RD;
            end
        end

        level_next = level_reg + LEVEL_W'(wr_fire) - LEVEL_W'(rd_fire);
        err_next   = err_reg
                     | ((level_reg == '0) != fifo_empty)
                     | ((level_reg == LEVEL_W'(DEPTH)) != fifo_full);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = wr_fire & (gnt == 1'(gi));
        end
    endgenerate

    assign p0_ready = ready[0];
    assign p1_ready = ready[1];
    assign fifo_din = gnt ? p1_data : p0_data;
    assign fifo_wr  = wr_fire;
    assign fifo_rd  = rd_fire;
    assign c_data   = fifo_dout;
    assign level    = level_reg;
    assign err      = err_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            turn_reg  <= TURN_RD;
            level_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            turn_reg  <= turn_next;
            level_reg <= level_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Self-checking bench for fifo_share_ctrl with a behavioural 3-entry FIFO
// attached and a reference model built from the handshake rules plus a data
// queue that stands for the FIFO contents.
module tb_fifo_share_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         p0_valid = 1'b0, p1_valid = 1'b0, c_ready = 1'b0;
    logic [W-1:0] p0_data = '0, p1_data = '0;
    logic         p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd;
    logic [W-1:0] c_data, fifo_din, fifo_dout;
    logic         fifo_full, fifo_empty;
    logic [1:0]   level;
    logic         err;

    always #5 clk = ~clk;

    fifo_share_ctrl #(.WIDTH(W), .DEPTH(3)) dut (
        .clk(clk), .resetn(resetn),
        .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
        .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .level(level), .err(err)
    );

    // Behavioural FIFO: ignores rd when wr is present, head reads 0 when empty.
    logic [W-1:0] mem [3];
    int unsigned  f_head = 0, f_cnt = 0;
    bit           force_ne = 1'b0;   // pretends the FIFO is non-empty
    bit           want_ne = 1'b0;

    assign fifo_full  = (f_cnt == 3);
    assign fifo_empty = force_ne ? 1'b0 : (f_cnt == 0);
    assign fifo_dout  = (f_cnt == 0) ? '0 : mem[f_head];

    always @(posedge clk) begin
        if (!resetn) begin
            f_head <= 0;
            f_cnt  <= 0;
        end else if (fifo_wr && f_cnt < 3) begin
            mem[(f_head + f_cnt) % 3] <= fifo_din;
            f_cnt <= f_cnt + 1;
        end else if (fifo_rd && f_cnt > 0) begin
            f_head <= (f_head + 1) % 3;
            f_cnt  <= f_cnt - 1;
        end
    end

    // Reference model state
    logic [W-1:0] sb[$];
    bit m_turn_rd = 1'b1, m_ptr = 1'b0, m_err = 1'b0;
    bit e_any, e_full, e_empty, e_cv, e_rd, e_wr, e_g, e_p0r, e_p1r, e_err;
    logic [W-1:0] e_din, e_cdata;
    logic [1:0]   e_level;

    int total = 0;
    int bad = 0;

    // Drive one cycle's inputs after the falling edge and derive expectations.
    task automatic set_in(input bit rn, input bit v0, input logic [W-1:0] d0,
                          input bit v1, input logic [W-1:0] d1, input bit cr);
        @(negedge clk);
        resetn = rn; p0_valid = v0; p0_data = d0;
        p1_valid = v1; p1_data = d1; c_ready = cr;
        force_ne = want_ne;
        #1;
        e_any   = v0 | v1;
        e_full  = (sb.size() == 3);
        e_empty = force_ne ? 1'b0 : (sb.size() == 0);
        e_cv    = rn && !e_empty && (m_turn_rd || !e_any || e_full);
        e_rd    = e_cv && cr;
        e_wr    = rn && e_any && !e_full && !e_rd;
        e_g     = (m_ptr ? v1 : v0) ? m_ptr : !m_ptr;
        e_p0r   = e_wr && !e_g;
        e_p1r   = e_wr && e_g;
        e_din   = e_g ? d1 : d0;
        e_cdata = (sb.size() > 0) ? sb[0] : '0;
        e_level = 2'(sb.size());
        e_err   = m_err;
    endtask

    // Advance the model past the coming rising edge.
    task automatic commit();
        if (!resetn) begin
            sb.delete();
            m_turn_rd = 1'b1;
            m_ptr = 1'b0;
            m_err = 1'b0;
        end else begin
            if (e_any && !e_full && !e_empty) begin
                if (e_rd) m_turn_rd = 1'b0;
                else if (e_wr) m_turn_rd = 1'b1;
            end
            if (e_wr) m_ptr = !e_g;
            if (((sb.size() == 0) != e_empty) || ((sb.size() == 3) != e_full))
                m_err = 1'b1;
            if (e_wr) begin
                $display("xfer in  p%0d data=%h", e_g, e_din);
                sb.push_back(e_din);
            end else if (e_rd && sb.size() > 0) begin
                $display("xfer out data=%h", sb[0]);
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom));
            total++;
            if ({p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd} !== 5'b0) begin
                bad++;
                $display("FAIL reset_hs: got %b want 00000", {p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd});
            end
            commit();
        end
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
            total++;
            if ({p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd, level, err} !== 8'b0) begin
                bad++;
                $display("FAIL idle: got hs/level/err=%b want 00000000", {p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd, level, err});
            end
            commit();
        end
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] vals [3];
        vals[0] = 32'hA1; vals[1] = 32'hA2; vals[2] = 32'hA3;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, vals[i], 1'b0, '0, 1'b0);
            total++;
            if (p0_ready !== 1'b1 || fifo_wr !== 1'b1 || fifo_din !== vals[i]) begin
                bad++;
                $display("FAIL fill_%0d: ready=%b wr=%b din=%h want 1 1 %h", i, p0_ready, fifo_wr, fifo_din, vals[i]);
            end
            commit();
        end
        set_in(1'b1, 1'b1, 32'hA4, 1'b0, '0, 1'b0);
        total++;
        if (p0_ready !== 1'b0 || level !== 2'd3 || c_valid !== 1'b1) begin
            bad++;
            $display("FAIL full: ready=%b level=%0d c_valid=%b want 0 3 1", p0_ready, level, c_valid);
        end
        commit();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
            total++;
            if (fifo_rd !== 1'b1 || c_data !== vals[i]) begin
                bad++;
                $display("FAIL drain_%0d: rd=%b data=%h want 1 %h", i, fifo_rd, c_data, vals[i]);
            end
            commit();
        end
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        total++;
        if (level !== 2'd0 || c_valid !== 1'b0) begin
            bad++;
            $display("FAIL drained: level=%0d c_valid=%b want 0 0", level, c_valid);
        end
        commit();
    endtask

    task automatic test_grant_alt();
        logic [W-1:0] order[$];
        logic [W-1:0] d0, d1;
        set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        commit();
        for (int i = 0; i < 3; i++) begin
            d0 = $urandom; d1 = $urandom;
            set_in(1'b1, 1'b1, d0, 1'b1, d1, 1'b0);
            total++;
            if (p0_ready !== (i % 2 == 0) || p1_ready !== (i % 2 == 1)
                || fifo_din !== ((i % 2 == 0) ? d0 : d1)) begin
                bad++;
                $display("FAIL grant_%0d: p0r=%b p1r=%b din=%h want p%0d", i, p0_ready, p1_ready, fifo_din, i % 2);
            end
            order.push_back((i % 2 == 0) ? d0 : d1);
            commit();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
            total++;
            if (fifo_rd !== 1'b1 || c_data !== order[i]) begin
                bad++;
                $display("FAIL grant_order_%0d: rd=%b data=%h want 1 %h", i, fifo_rd, c_data, order[i]);
            end
            commit();
        end
    endtask

    task automatic test_alternate();
        int n_rd = 0;
        int n_wr = 0;
        set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        commit();
        set_in(1'b1, 1'b1, $urandom, 1'b0, '0, 1'b0);
        commit();
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 1'b1, $urandom, 1'b0, '0, 1'b1);
            total++;
            if (fifo_wr !== e_wr || fifo_rd !== e_rd || (fifo_wr && fifo_rd)) begin
                bad++;
                $display("FAIL alt_%0d: wr=%b rd=%b want %b %b", i, fifo_wr, fifo_rd, e_wr, e_rd);
            end
            if (e_rd) begin
                total++;
                if (c_data !== e_cdata) begin
                    bad++;
                    $display("FAIL alt_data_%0d: data=%h want %h", i, c_data, e_cdata);
                end
            end
            n_rd += int'(fifo_rd);
            n_wr += int'(fifo_wr);
            commit();
        end
        total++;
        if (n_rd < 4 || n_wr < 4) begin
            bad++;
            $display("FAIL alt_share: reads=%0d writes=%0d want >=4 each", n_rd, n_wr);
        end
    endtask

    task automatic test_mid_reset();
        set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        commit();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b1, $urandom, 1'b0, '0, 1'b0);
            commit();
        end
        set_in(1'b1, 1'b1, $urandom, 1'b1, $urandom, 1'b1);
        total++;
        if (level !== 2'd2) begin
            bad++;
            $display("FAIL mid_level: level=%0d want 2", level);
        end
        set_in(1'b0, 1'b1, $urandom, 1'b1, $urandom, 1'b1);
        total++;
        if ({p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd} !== 5'b0) begin
            bad++;
            $display("FAIL mid_rst_hs: got %b want 00000", {p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd});
        end
        commit();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
            total++;
            if (level !== 2'd0 || c_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_after: level=%0d c_valid=%b want 0 0", level, c_valid);
            end
            commit();
        end
        set_in(1'b1, 1'b1, 32'h55, 1'b1, 32'h66, 1'b0);
        total++;
        if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_ptr: p0r=%b p1r=%b want 1 0", p0_ready, p1_ready);
        end
        commit();
    endtask

    task automatic test_err();
        set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        commit();
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        commit();
        want_ne = 1'b1;
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        commit();
        want_ne = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
            total++;
            if (err !== 1'b1) begin
                bad++;
                $display("FAIL err_sticky_%0d: err=%b want 1", i, err);
            end
            commit();
        end
        set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        commit();
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: err=%b want 0", err);
        end
        commit();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 49) != 0, 1'($urandom), $urandom,
                   1'($urandom), $urandom, $urandom_range(0, 2) != 0);
            total++;
            if ({p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd} !== {e_p0r, e_p1r, e_cv, e_wr, e_rd}) begin
                bad++;
                $display("FAIL rnd_hs_%0d: got %b want %b", i, {p0_ready, p1_ready, c_valid, fifo_wr, fifo_rd}, {e_p0r, e_p1r, e_cv, e_wr, e_rd});
            end
            total++;
            if (level !== e_level || err !== e_err) begin
                bad++;
                $display("FAIL rnd_state_%0d: level=%0d err=%b want %0d %b", i, level, err, e_level, e_err);
            end
            if (e_wr) begin
                total++;
                if (fifo_din !== e_din) begin
                    bad++;
                    $display("FAIL rnd_din_%0d: din=%h want %h", i, fifo_din, e_din);
                end
            end
            if (e_rd) begin
                total++;
                if (c_data !== e_cdata) begin
                    bad++;
                    $display("FAIL rnd_data_%0d: data=%h want %h", i, c_data, e_cdata);
                end
            end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_grant_alt();
        test_alternate();
        test_mid_reset();
        test_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_share_ctrl.md
# fifo_share_ctrl

Controller that shares one 3-entry FIFO between two producers and one consumer. It arbitrates producer writes round-robin and schedules FIFO write against FIFO read. The FIFO ignores rd when wr is asserted in the same cycle, so this block never issues both; it alternates under contention so neither side starves. It also keeps a shadow occupancy count and flags any disagreement with the FIFO's full/empty.

## Interface
- WIDTH, 32, data width.
- DEPTH, 3, FIFO capacity; fixed, used only by the shadow count.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low; also resets the attached FIFO.
- p0_valid, p1_valid  in  1  producer offers data.
- p0_data, p1_data  in  WIDTH  producer payload.
- p0_ready, p1_ready  out  1  producer transfer accepted this cycle.
- c_valid  out  1  consumer data available.
- c_data  out  WIDTH  consumer payload, equals fifo_dout.
- c_ready  in  1  consumer accepts.
- fifo_wr, fifo_rd  out  1  FIFO strobes.
- fifo_din  out  WIDTH  FIFO write data.
- fifo_full, fifo_empty  in  1  FIFO status.
- fifo_dout  in  WIDTH  FIFO head; 0 when empty.
- level  out  2  shadow occupancy, 0..3.
- err  out  1  sticky mismatch flag.

## Operation
- any_p = p0_valid | p1_valid.
- c_valid = !fifo_empty & (turn==TURN_RD | !any_p | fifo_full).
  - Depends only on turn, any_p and FIFO status, never on c_ready.
- rd_fire = c_valid & c_ready; fifo_rd = rd_fire.
- wr_fire = any_p & !fifo_full & !rd_fire; fifo_wr = wr_fire.
  - fifo_wr and fifo_rd are never both 1.
- Producer grant:
  - Grant goes to p[ptr] if valid, else to the other producer.
  - fifo_din = granted data.
  - The granted producer's ready = wr_fire; the other's ready = 0.
  - On wr_fire, ptr <= index of the non-granted producer.
- Contention: a cycle with any_p & !fifo_full & !fifo_empty.
  - If rd_fire, turn <= TURN_WR.
  - If wr_fire, turn <= TURN_RD.
  - Otherwise turn holds.
  - turn changes only in contention cycles.
- Shadow count:
  - level += wr_fire, −= rd_fire; saturation never occurs in legal operation.
- err sets and stays set when either holds:
  - (level==0) != fifo_empty
  - (level==DEPTH) != fifo_full
- Reset, resetn low at the clock edge:
  - Registers: turn=TURN_RD, ptr=0, level=0, err=0.
  - While resetn is low, p*_ready, c_valid, fifo_wr and fifo_rd are forced 0 combinationally.
  - A mid-operation reset discards in-flight state. Producers must re-offer.

## Timing
- All handshake outputs are combinational from current inputs and registers. No output flop.
- Write-to-read latency:
  - Write in cycle N; fifo_empty falls and c_valid can rise in N+1.
  - Minimum producer-to-consumer latency is 1 cycle.
- Throughput:
  - 1 transfer per cycle total.
  - Under sustained contention, writes and reads alternate: 50% each.
- Full: producers get no ready; reads proceed whenever c_ready is high.
- Empty: c_valid=0; writes proceed.
- Both producers continuously valid: grants alternate p0, p1, p0, … starting with p0 after reset.
- c_ready low while turn==TURN_RD: the write is taken that cycle and turn stays TURN_RD.

## Structure
- Package fifo_share_pkg:
  - turn_t enum {TURN_RD, TURN_WR}.
  - localparam DEPTH=3.
  - Level width constant: 2 bits.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], advance.
  - Outputs: gnt index, gnt_valid.
  - Owns the ptr register.
- Top instantiates rr_arb2 and holds turn, level and err.
- The FIFO is external and connected by the parent.

## Test plan
- Reset then idle: all outputs 0, level=0, err=0; no FIFO strobes for 10 cycles.
- p0 sends 0xA1, 0xA2, 0xA3 with c_ready=0:
  - Three writes; level=3; fifo_full=1; p0_ready=0 on the 4th offer.
  - Then c_ready=1 reads A1, A2, A3 in order.
- p0 and p1 both continuously valid, consumer idle:
  - Grants are p0, p1, p0.
  - Accepted data order matches grant order.
- FIFO holding 1 entry, p0 valid and c_ready=1 continuously:
  - Strobes alternate rd, wr, rd, wr, …
  - fifo_wr & fifo_rd never both 1.
  - Consumer receives the data in order.
- Assert resetn low mid-transfer with level=2:
  - Next cycle level=0, turn=TURN_RD, ptr=0.
  - c_valid=0 until a new write.
- Force fifo_empty=0 while level=0: err=1 next cycle and remains 1 until reset.
